// File: rtl/pll_reset_supervisor_if.sv
// rtl/pll_reset_supervisor_if.sv - PLL control and system reset signal bundle
//
// Groups the PLL-facing and system-facing signals of the supervisor.
//   locked       : PLL lock indication, asynchronous to refclk
//   pll_rst      : PLL reset input, active-high
//   sys_rst      : system reset for logic on the PLL output clocks, active-high
//   ready        : inverse of sys_rst, high only while running
//   relock_count : saturating count of lock losses seen while running
//   fail         : sticky PLL-failed-to-lock flag
// Modports: master = supervisor side, slave = PLL/system side.

interface pll_reset_supervisor_if;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] relock_count;
    logic       fail;

    modport master (
        input  locked,
        output pll_rst,
        output sys_rst,
        output ready,
        output relock_count,
        output fail
    );

    modport slave (
        output locked,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  relock_count,
        input  fail
    );
endinterface

// File: rtl/pll_reset_supervisor.sv
// rtl/pll_reset_supervisor.sv - PLL reset pulse, lock qualification and system reset release
//
// Runs on the free-running reference clock. Pulses the PLL reset, waits for
// the synchronized lock to stay high for STABLE_CYCLES, then releases the
// system reset. A lock loss while running re-asserts the system reset and
// re-initialises the PLL.
//
// Ports:
//   refclk : reference clock, the only clock
//   rst    : synchronous reset, active-high
//   pll    : pll_reset_supervisor_if.master (locked in; pll_rst, sys_rst,
//            ready, relock_count, fail out)
//
// Optional feature macro: PLL_SUP_RETRY_EN
//   defined   : WAIT_LOCK times out after LOCK_TIMEOUT cycles and retries the
//               PLL reset; after MAX_RETRIES retries a further timeout enters
//               the sticky FAIL state.
//   undefined : WAIT_LOCK waits forever, fail is tied low.

module pll_reset_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int MAX_RETRIES   = 7
) (
    input  logic                          refclk,
    input  logic                          rst,
    pll_reset_supervisor_if.master        pll
);

    localparam int MAX_RS = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
`ifdef PLL_SUP_RETRY_EN
    localparam int MAX_PARAM = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
`else
    localparam int MAX_PARAM = MAX_RS;
`endif
    localparam int CNT_W = $clog2(MAX_PARAM) + 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_SUP_RETRY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam int               RETRY_W      = $clog2(MAX_RETRIES + 1) + 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES);
`endif

`ifdef PLL_SUP_RETRY_EN
    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       relock_q, relock_d;
    logic             locked_m, locked_s;
    logic             pll_rst_q, sys_rst_q, ready_q;
`ifdef PLL_SUP_RETRY_EN
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               fail_q;
`endif

    // Two-flop synchronizer; nothing downstream looks at raw locked.
    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= pll.locked;
            locked_s <= locked_m;
        end
    end

    // One shared counter; every state transition reloads it with zero, and
    // states that do not count hold it, so it can never wrap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        relock_d = relock_q;
`ifdef PLL_SUP_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end
`ifdef PLL_SUP_RETRY_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LAST) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_PLL_RST;
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_STABLE: begin
                // A drop beats the terminal count on the same cycle.
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
`ifdef PLL_SUP_RETRY_EN
                    retry_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end
`ifdef PLL_SUP_RETRY_EN
            S_FAIL: begin
                state_d = S_FAIL;
            end
`endif
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are flops loaded from the next-state decode, so each one equals
    // a decode of the state register with no path from locked.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            relock_q  <= 8'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
`ifdef PLL_SUP_RETRY_EN
            retry_q   <= '0;
            fail_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            relock_q  <= relock_d;
            sys_rst_q <= (state_d != S_RUN);
            ready_q   <= (state_d == S_RUN);
`ifdef PLL_SUP_RETRY_EN
            retry_q   <= retry_d;
            fail_q    <= (state_d == S_FAIL);
            pll_rst_q <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
`else
            pll_rst_q <= (state_d == S_PLL_RST);
`endif
        end
    end

    assign pll.pll_rst      = pll_rst_q;
    assign pll.sys_rst      = sys_rst_q;
    assign pll.ready        = ready_q;
    assign pll.relock_count = relock_q;
`ifdef PLL_SUP_RETRY_EN
    assign pll.fail         = fail_q;
`else
    assign pll.fail         = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// tb/tb_pll_reset_supervisor.sv - self-checking bench for pll_reset_supervisor

module tb_pll_reset_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int MAX_RETRIES   = 2;

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    pll_reset_supervisor_if pll_bus ();

    pll_reset_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .pll   (pll_bus)
    );

    always #10 refclk = ~refclk;

    typedef struct {
        logic       rst;
        logic       locked;
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic [7:0] relock_count;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic l, input logic pr, input logic sr,
                       input logic rdy, input logic [7:0] rc, input int n);
        vec_t v;
        v.rst = r; v.locked = l; v.pll_rst = pr; v.sys_rst = sr;
        v.ready = rdy; v.relock_count = rc;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive inputs away from the active edge, then sample just after it.
    task automatic step(input logic r, input logic l);
        @(negedge refclk);
        rst = r;
        pll_bus.locked = l;
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_ready(input string name, input int bound);
        int n = 0;
        while (pll_bus.ready !== 1'b1 && n < bound) begin
            step(1'b0, 1'b1);
            n++;
        end
        check(name, pll_bus.ready, 1'b1);
    endtask

    initial begin
        int bad;
        pll_bus.locked = 1'b0;

        // Power-up, loss in RUN, reset mid-RUN, chatter in STABLE.
        add(1, 0, 1, 1, 0, 0, 3);
        add(0, 0, 1, 1, 0, 0, 3);
        add(0, 0, 0, 1, 0, 0, 7);
        add(0, 1, 0, 1, 0, 0, 10);
        add(0, 1, 0, 0, 1, 0, 4);
        add(0, 0, 0, 0, 1, 0, 2);
        add(0, 0, 1, 1, 0, 1, 3);
        add(0, 1, 1, 1, 0, 1, 1);
        add(0, 1, 0, 1, 0, 1, 9);
        add(0, 1, 0, 0, 1, 1, 2);
        add(1, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 3);
        add(0, 1, 0, 1, 0, 0, 4);
        add(0, 0, 0, 1, 0, 0, 3);
        add(0, 1, 0, 1, 0, 0, 10);
        add(0, 1, 0, 0, 1, 0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].locked);
            check($sformatf("vec%0d pll_rst", i), pll_bus.pll_rst, vecs[i].pll_rst);
            check($sformatf("vec%0d sys_rst", i), pll_bus.sys_rst, vecs[i].sys_rst);
            check($sformatf("vec%0d ready", i), pll_bus.ready, vecs[i].ready);
            check($sformatf("vec%0d relock_count", i), pll_bus.relock_count, vecs[i].relock_count);
            check($sformatf("vec%0d fail", i), pll_bus.fail, 1'b0);
        end

        // 300 lock losses in RUN: relock_count saturates at 255.
        for (int k = 0; k < 300; k++) begin
            for (int j = 0; j < 5; j++) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            wait_ready($sformatf("relock%0d ready", k), 40);
            if (k == 0) check("relock first count", pll_bus.relock_count, 1);
            if (k == 254) check("relock reaches 255", pll_bus.relock_count, 255);
        end
        check("relock saturated", pll_bus.relock_count, 255);

        // Drop seen on the same cycle as the stable terminal count.
        for (int j = 0; j < 11; j++) step(1'b0, 1'b0);
        check("saturated after loss", pll_bus.relock_count, 255);
        for (int j = 0; j < 8; j++) step(1'b0, 1'b1);
        for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
        check("drop beats terminal sys_rst", pll_bus.sys_rst, 1'b1);
        check("drop beats terminal ready", pll_bus.ready, 1'b0);

        // Reset mid-STABLE.
        for (int j = 0; j < 5; j++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("rst mid-stable pll_rst", pll_bus.pll_rst, 1'b1);
        check("rst mid-stable sys_rst", pll_bus.sys_rst, 1'b1);
        check("rst mid-stable ready", pll_bus.ready, 1'b0);
        check("rst mid-stable relock_count", pll_bus.relock_count, 0);
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1);
        check("post-rst pll_rst held", pll_bus.pll_rst, 1'b1);
        step(1'b0, 1'b1);
        check("post-rst pll_rst released", pll_bus.pll_rst, 1'b0);
        wait_ready("post-rst ready", 40);

`ifdef PLL_SUP_RETRY_EN
        // Lock never arrives: three pulses 36 cycles apart, then FAIL.
        step(1'b1, 1'b0);
        bad = 0;
        for (int e = 1; e <= 120; e++) begin
            logic exp_pr;
            step(1'b0, 1'b0);
            exp_pr = (e < 4) || (e >= 36 && e < 40) || (e >= 72 && e < 76) || (e >= 108);
            if (pll_bus.pll_rst !== exp_pr || pll_bus.fail !== (e >= 108) ||
                pll_bus.sys_rst !== 1'b1)
                bad++;
        end
        check("retry sequence bad cycles", bad, 0);
        bad = 0;
        for (int e = 0; e < 50; e++) begin
            step(1'b0, 1'b1);
            if (pll_bus.fail !== 1'b1 || pll_bus.pll_rst !== 1'b1 || pll_bus.sys_rst !== 1'b1)
                bad++;
        end
        check("fail sticky bad cycles", bad, 0);
        step(1'b1, 1'b1);
        check("fail cleared by rst", pll_bus.fail, 1'b0);
        wait_ready("recover after fail", 40);
`else
        // Lock never arrives: one pulse, then wait forever without failing.
        step(1'b1, 1'b0);
        bad = 0;
        for (int e = 1; e <= 10000; e++) begin
            step(1'b0, 1'b0);
            if (pll_bus.pll_rst !== (e < 4) || pll_bus.sys_rst !== 1'b1 ||
                pll_bus.fail !== 1'b0 || pll_bus.ready !== 1'b0)
                bad++;
        end
        check("no-lock hold bad cycles", bad, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
